// File: rtl/jtvigil_colmix.sv
// Colour mixer: layer priority, CPU-writable 5-bit RGB palette with a
// time-multiplexed video read port, and blanking delayed to match colour latency.
module jtvigil_colmix #(
  parameter logic [3:0] PRIO_PAL  = 4'hC,
  parameter int         BLANK_DLY = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pxl_cen,
  input  logic        LHBL,
  input  logic        LVBL,
  input  logic [10:0] main_addr,
  input  logic [7:0]  main_dout,
  output logic [7:0]  main_din,
  input  logic        main_rnw,
  input  logic        pal_cs,
  input  logic [7:0]  scr1_pxl,
  input  logic [6:0]  scr2_pxl,
  input  logic [6:0]  obj_pxl,
  output logic [4:0]  red,
  output logic [4:0]  green,
  output logic [4:0]  blue,
  output logic        LHBL_dly,
  output logic        LVBL_dly
);

  typedef enum logic [2:0] {IDLE, RD_R, RD_G, RD_B, DONE} state_t;

  state_t         state, state_next;
  logic [4:0]     pal [0:2047];
  logic [8:0]     idx, idx_in;
  logic [4:0]     r_nx, g_nx, b_nx, vid_q;
  logic [1:0]     rd_comp;
  logic           cap_r, cap_g, cap_b, fetch_done;
  logic           obj_opaque, s1_opaque, show;
  logic [BLANK_DLY-1:0] lhbl_sr, lvbl_sr, lhbl_shift, lvbl_shift;

  // High-priority scroll-1 palettes beat sprites; scr2 is the opaque backdrop
  always_comb begin
    obj_opaque = obj_pxl[3:0] != 4'd0;
    s1_opaque  = scr1_pxl[3:0] != 4'd0;
    if (s1_opaque && scr1_pxl[7:4] >= PRIO_PAL) idx_in = {1'b0, scr1_pxl};
    else if (obj_opaque)                        idx_in = {2'b10, obj_pxl};
    else if (s1_opaque)                         idx_in = {1'b0, scr1_pxl};
    else                                        idx_in = {2'b11, scr2_pxl};
  end

  // Component 3 is unmapped: writes dropped, reads return zero
  always_ff @(posedge clk) begin
    if (pal_cs && !main_rnw && main_addr[10:9] != 2'd3)
      pal[main_addr] <= main_dout[4:0];
    main_din <= (main_addr[10:9] == 2'd3) ? 8'd0 : {3'b000, pal[main_addr]};
  end

  // Video read is asynchronous, so a same-edge CPU write is seen only next time
  assign vid_q = pal[{rd_comp, idx}];

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    if (pxl_cen) state_next = RD_R;
    else begin
      case (state)
        IDLE:    state_next = IDLE;
        RD_R:    state_next = RD_G;
        RD_G:    state_next = RD_B;
        RD_B:    state_next = DONE;
        DONE:    state_next = IDLE;
        default: state_next = IDLE;
      endcase
    end
  end

  always_comb begin
    rd_comp    = 2'd0;
    cap_r      = 1'b0;
    cap_g      = 1'b0;
    cap_b      = 1'b0;
    fetch_done = 1'b0;
    case (state)
      RD_R:    begin rd_comp = 2'd0; cap_r = 1'b1; end
      RD_G:    begin rd_comp = 2'd1; cap_g = 1'b1; end
      RD_B:    begin rd_comp = 2'd2; cap_b = 1'b1; end
      default: fetch_done = 1'b1;
    endcase
  end

  always_comb begin
    lhbl_shift[0] = LHBL;
    lvbl_shift[0] = LVBL;
    for (int i = 1; i < BLANK_DLY; i++) begin
      lhbl_shift[i] = lhbl_sr[i-1];
      lvbl_shift[i] = lvbl_sr[i-1];
    end
    show = lhbl_shift[BLANK_DLY-1] & lvbl_shift[BLANK_DLY-1];
  end

  // An aborted fetch leaves r/g/b_nx incomplete, so the output holds instead
  always_ff @(posedge clk) begin
    if (rst) begin
      idx     <= 9'd0;
      r_nx    <= 5'd0;
      g_nx    <= 5'd0;
      b_nx    <= 5'd0;
      red     <= 5'd0;
      green   <= 5'd0;
      blue    <= 5'd0;
      lhbl_sr <= '0;
      lvbl_sr <= '0;
    end else begin
      if (cap_r) r_nx <= vid_q;
      if (cap_g) g_nx <= vid_q;
      if (cap_b) b_nx <= vid_q;
      if (pxl_cen) begin
        idx     <= idx_in;
        lhbl_sr <= lhbl_shift;
        lvbl_sr <= lvbl_shift;
        if (!show) begin
          red   <= 5'd0;
          green <= 5'd0;
          blue  <= 5'd0;
        end else if (fetch_done) begin
          red   <= r_nx;
          green <= g_nx;
          blue  <= b_nx;
        end
      end
    end
  end

  assign LHBL_dly = lhbl_sr[BLANK_DLY-1];
  assign LVBL_dly = lvbl_sr[BLANK_DLY-1];

endmodule

// File: tb/tb_jtvigil_colmix.sv
// Directed bench for jtvigil_colmix: palette port, priority, blanking and
// pixel-enable spacing, with hand-computed expected colours.
module tb_jtvigil_colmix;

  logic        clk = 1'b0;
  logic        rst, pxl_cen, LHBL, LVBL, main_rnw, pal_cs;
  logic [10:0] main_addr;
  logic [7:0]  main_dout, main_din, scr1_pxl;
  logic [6:0]  scr2_pxl, obj_pxl;
  logic [4:0]  red, green, blue;
  logic        LHBL_dly, LVBL_dly;

  int checks = 0;
  int failures = 0;

  localparam logic [14:0] COL_A   = {5'h1F, 5'h0A, 5'h03};
  localparam logic [14:0] COL_OBJ = {5'h11, 5'h12, 5'h13};
  localparam logic [14:0] COL_S1  = {5'h01, 5'h02, 5'h03};
  localparam logic [14:0] COL_PRI = {5'h0C, 5'h0D, 5'h0E};
  localparam logic [14:0] COL_S2  = {5'h15, 5'h16, 5'h17};

  jtvigil_colmix dut (
    .clk(clk), .rst(rst), .pxl_cen(pxl_cen), .LHBL(LHBL), .LVBL(LVBL),
    .main_addr(main_addr), .main_dout(main_dout), .main_din(main_din),
    .main_rnw(main_rnw), .pal_cs(pal_cs), .scr1_pxl(scr1_pxl),
    .scr2_pxl(scr2_pxl), .obj_pxl(obj_pxl), .red(red), .green(green),
    .blue(blue), .LHBL_dly(LHBL_dly), .LVBL_dly(LVBL_dly)
  );

  always #5 clk = ~clk;

  task automatic cen_tick(input int gap);
    @(negedge clk) pxl_cen = 1'b1;
    @(negedge clk) pxl_cen = 1'b0;
    repeat (gap - 1) @(negedge clk);
  endtask

  task automatic cpu_write(input logic [10:0] a, input logic [7:0] d);
    @(negedge clk);
    main_addr = a; main_dout = d; pal_cs = 1'b1; main_rnw = 1'b0;
    @(negedge clk);
    pal_cs = 1'b0; main_rnw = 1'b1;
  endtask

  task automatic cpu_rgb(input logic [8:0] i, input logic [14:0] c);
    cpu_write({2'd0, i}, {3'b000, c[14:10]});
    cpu_write({2'd1, i}, {3'b000, c[9:5]});
    cpu_write({2'd2, i}, {3'b000, c[4:0]});
  endtask

  task automatic set_pixel(input logic [7:0] s1, input logic [6:0] ob, input logic [6:0] s2);
    scr1_pxl = s1; obj_pxl = ob; scr2_pxl = s2;
  endtask

  task automatic check_rgb(input string name, input logic [14:0] exp);
    checks++;
    if ({red, green, blue} !== exp) begin
      failures++;
      $display("[TB] FAIL %s: rgb=%h/%h/%h expected=%h/%h/%h", name, red, green, blue,
               exp[14:10], exp[9:5], exp[4:0]);
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; pxl_cen = 1'b0; LHBL = 1'b1; LVBL = 1'b1;
    main_addr = '0; main_dout = '0; main_rnw = 1'b1; pal_cs = 1'b0;
    set_pixel(8'h00, 7'h00, 7'h00);
    repeat (3) @(negedge clk);
    check_rgb("reset_rgb", 15'd0);
    checks++;
    if ({LHBL_dly, LVBL_dly} !== 2'b00) begin
      failures++;
      $display("[TB] FAIL reset_blank: got=%b expected=00", {LHBL_dly, LVBL_dly});
    end
    rst = 1'b0;
  endtask

  task automatic test_cpu_port;
    cpu_rgb(9'h005, COL_A);
    cpu_write(11'h605, 8'h1F);
    @(negedge clk) begin main_addr = 11'h205; pal_cs = 1'b1; end
    @(negedge clk);
    checks++;
    if (main_din !== 8'h0A) begin
      failures++;
      $display("[TB] FAIL read_0x205: got=%h expected=0a", main_din);
    end
    main_addr = 11'h605;
    @(negedge clk);
    checks++;
    if (main_din !== 8'h00) begin
      failures++;
      $display("[TB] FAIL read_comp3: got=%h expected=00", main_din);
    end
    pal_cs = 1'b0;
  endtask

  task automatic test_basic_colour;
    LHBL = 1'b1; LVBL = 1'b1;
    set_pixel(8'h05, 7'h00, 7'h00);
    cen_tick(4);
    cen_tick(4);
    check_rgb("basic_colour", COL_A);
    checks++;
    if ({LHBL_dly, LVBL_dly} !== 2'b11) begin
      failures++;
      $display("[TB] FAIL basic_blank: got=%b expected=11", {LHBL_dly, LVBL_dly});
    end
  endtask

  task automatic test_priority;
    cpu_rgb(9'h112, COL_OBJ);
    cpu_rgb(9'h035, COL_S1);
    cpu_rgb(9'h0C5, COL_PRI);
    cpu_rgb(9'h1FF, COL_S2);
    set_pixel(8'h35, 7'h12, 7'h00); cen_tick(4); cen_tick(4);
    check_rgb("obj_over_scr1", COL_OBJ);
    set_pixel(8'hC5, 7'h12, 7'h00); cen_tick(4); cen_tick(4);
    check_rgb("prio_scr1", COL_PRI);
    set_pixel(8'h35, 7'h10, 7'h00); cen_tick(4); cen_tick(4);
    check_rgb("scr1_over_clear_obj", COL_S1);
    set_pixel(8'h30, 7'h12, 7'h00); cen_tick(4); cen_tick(4);
    check_rgb("obj_over_clear_scr1", COL_OBJ);
    set_pixel(8'h40, 7'h50, 7'h7F); cen_tick(4); cen_tick(4);
    check_rgb("scr2_fallback", COL_S2);
    set_pixel(8'hC0, 7'h00, 7'h7F); cen_tick(4); cen_tick(4);
    check_rgb("scr2_under_clear_prio", COL_S2);
  endtask

  task automatic test_blanking;
    logic [6:0] lh = 7'b1111011;
    logic [6:0] lv = 7'b1101111;
    set_pixel(8'h05, 7'h00, 7'h00);
    for (int i = 0; i < 7; i++) begin
      LHBL = lh[i]; LVBL = lv[i];
      cen_tick(4);
      if (i >= 1) begin
        check_rgb($sformatf("blank_rgb_%0d", i - 1), (lh[i-1] & lv[i-1]) ? COL_A : 15'd0);
        checks++;
        if ({LHBL_dly, LVBL_dly} !== {lh[i-1], lv[i-1]}) begin
          failures++;
          $display("[TB] FAIL blank_dly_%0d: got=%b expected=%b", i - 1,
                   {LHBL_dly, LVBL_dly}, {lh[i-1], lv[i-1]});
        end
      end
    end
    LHBL = 1'b1; LVBL = 1'b1;
  endtask

  task automatic test_back_to_back;
    set_pixel(8'h05, 7'h00, 7'h00); cen_tick(4);
    set_pixel(8'h35, 7'h12, 7'h00); cen_tick(2);
    check_rgb("b2b_first", COL_A);
    cen_tick(2);
    check_rgb("b2b_hold1", COL_A);
    cen_tick(4);
    check_rgb("b2b_hold2", COL_A);
    cen_tick(4);
    check_rgb("b2b_recover", COL_OBJ);
  endtask

  task automatic test_reset_mid_fetch;
    set_pixel(8'h05, 7'h00, 7'h00);
    @(negedge clk) pxl_cen = 1'b1;
    @(negedge clk) pxl_cen = 1'b0;
    @(negedge clk) rst = 1'b1;
    @(negedge clk) rst = 1'b0;
    check_rgb("midfetch_rgb", 15'd0);
    checks++;
    if ({LHBL_dly, LVBL_dly} !== 2'b00) begin
      failures++;
      $display("[TB] FAIL midfetch_blank: got=%b expected=00", {LHBL_dly, LVBL_dly});
    end
    @(negedge clk) begin main_addr = 11'h005; pal_cs = 1'b1; end
    @(negedge clk);
    checks++;
    if (main_din !== 8'h1F) begin
      failures++;
      $display("[TB] FAIL midfetch_palette: got=%h expected=1f", main_din);
    end
    pal_cs = 1'b0;
    cen_tick(4);
    check_rgb("midfetch_still_blank", 15'd0);
    cen_tick(4);
    check_rgb("midfetch_recover", COL_A);
  endtask

  initial begin
    test_reset;
    test_cpu_port;
    test_basic_colour;
    test_priority;
    test_blanking;
    test_back_to_back;
    test_reset_mid_fetch;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
